// File: rtl/mem_dma_if.sv
// Command and memory-port signals of the block-transfer initiator.
// master = the DMA engine; slave = whoever issues commands and hosts the memory.
interface mem_dma_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = ADDR_W + 1
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_data, mem_read_data,
        output busy, done, mem_addr, mem_write_en, mem_write_data
    );

    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_data, mem_read_data,
        input  busy, done, mem_addr, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/mem_dma.sv
// Block-transfer initiator for the single-port data memory: COPY a region
// word by word (read cycle, then write cycle) or FILL a region with a constant.
module mem_dma #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    // Write-data register doubles as the copy buffer and the latched fill constant.
    logic [DATA_W-1:0] wdata_q;

    logic [LEN_W-1:0]  count_nxt;

    // Words completed after the write currently on the bus.
    assign count_nxt = count + LEN_W'(1);

    // Command FSM; every output is set one edge ahead so it is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            count   <= '0;
            src_ptr <= '0;
            dst_ptr <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        len_q   <= bus.len;
                        src_ptr <= bus.src_addr;
                        dst_ptr <= bus.dst_addr;
                        count   <= '0;
                        if (bus.len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (!bus.mode) begin
                            state  <= RD;
                            busy_q <= 1'b1;
                            addr_q <= bus.src_addr;
                        end else begin
                            state   <= WR;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.dst_addr;
                            we_q    <= 1'b1;
                            wdata_q <= bus.fill_data;
                        end
                    end
                end
                RD: begin
                    state   <= WR;
                    addr_q  <= dst_ptr;
                    we_q    <= 1'b1;
                    wdata_q <= bus.mem_read_data;
                end
                WR: begin
                    count   <= count_nxt;
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    if (count_nxt == len_q) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end else if (!mode_q) begin
                        state   <= RD;
                        addr_q  <= src_ptr + ADDR_W'(1);
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end else begin
                        // FILL keeps strobe and constant, only the address advances.
                        addr_q <= dst_ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_en   = we_q;
    assign bus.mem_write_data = wdata_q;
endmodule

// File: tb/tb_mem_dma.sv
// Randomized self-checking bench for mem_dma with a word-level reference model.
module tb_mem_dma;
    logic clk;
    logic rst_n;

    mem_dma_if #(.ADDR_W(6), .DATA_W(32), .LEN_W(7)) bus ();

    mem_dma #(.ADDR_W(6), .DATA_W(32), .LEN_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Memory stub: combinational read, write on rising edge; bench pokes when idle.
    logic [31:0] ram     [64];
    logic [31:0] ref_mem [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    assign bus.mem_read_data = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write_en) ram[bus.mem_addr] <= bus.mem_write_data;
        else if (pre_we)      ram[pre_addr]     <= pre_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < 64; i++) check(tag, ram[i], ref_mem[i]);
    endtask

    // Issue one command and check every cycle against the timing rules;
    // inject > 0 re-asserts start with other arguments in that cycle.
    task automatic run_cmd(input logic m, input logic [5:0] s, input logic [5:0] d,
                           input logic [6:0] n, input logic [31:0] f, input int inject);
        int          n_i;
        int          exp_done;
        int          k;
        logic [31:0] v;
        n_i      = int'(n);
        exp_done = (n_i == 0) ? 1 : (m ? n_i + 1 : 2 * n_i + 1);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.src_addr  = s;
        bus.dst_addr  = d;
        bus.len       = n;
        bus.fill_data = f;
        for (int c = 1; c <= exp_done; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == inject) begin
                bus.start     = 1'b1;
                bus.mode      = ~m;
                bus.src_addr  = 6'($urandom);
                bus.dst_addr  = 6'($urandom);
                bus.len       = 7'($urandom_range(1, 64));
                bus.fill_data = $urandom;
            end
            check("busy", 32'(bus.busy), 32'(c < exp_done));
            check("done", 32'(bus.done), 32'(c == exp_done));
            if (c < exp_done) begin
                if (m) begin
                    k = c - 1;
                    check("fill_we", 32'(bus.mem_write_en), 32'd1);
                    check("fill_addr", 32'(bus.mem_addr), 32'(6'(d + 6'(k))));
                    check("fill_data", bus.mem_write_data, f);
                    ref_mem[6'(d + 6'(k))] = f;
                end else if ((c % 2) == 1) begin
                    k = (c - 1) / 2;
                    check("rd_we", 32'(bus.mem_write_en), 32'd0);
                    check("rd_addr", 32'(bus.mem_addr), 32'(6'(s + 6'(k))));
                end else begin
                    k = c / 2 - 1;
                    v = ref_mem[6'(s + 6'(k))];
                    check("wr_we", 32'(bus.mem_write_en), 32'd1);
                    check("wr_addr", 32'(bus.mem_addr), 32'(6'(d + 6'(k))));
                    check("wr_data", bus.mem_write_data, v);
                    ref_mem[6'(d + 6'(k))] = v;
                end
            end else begin
                check("done_we", 32'(bus.mem_write_en), 32'd0);
                check("done_addr", 32'(bus.mem_addr), 32'd0);
                check("done_wdata", bus.mem_write_data, 32'd0);
            end
        end
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_we", 32'(bus.mem_write_en), 32'd0);
        end
        compare_mem("mem");
    endtask

    // Global time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        rst_n         = 1'b0;
        pre_we        = 1'b0;
        pre_addr      = '0;
        pre_data      = '0;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.len       = '0;
        bus.fill_data = '0;

        // Random initial contents while the DMA is held in reset.
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_we", 32'(bus.mem_write_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_cmd(1'b1, 6'd0, 6'd4, 7'd3, 32'hDEADBEEF, 0);
        poke(6'd0, 32'h11); poke(6'd1, 32'h22); poke(6'd2, 32'h33); poke(6'd3, 32'h44);
        run_cmd(1'b0, 6'd0, 6'd32, 7'd4, 32'h0, 0);
        run_cmd(1'b0, 6'd62, 6'd10, 7'd4, 32'h0, 0);
        run_cmd(1'b1, 6'd0, 6'd63, 7'd2, 32'hCAFE0001, 0);
        run_cmd(1'b1, 6'd7, 6'd9, 7'd0, 32'h12345678, 0);
        run_cmd(1'b0, 6'd7, 6'd9, 7'd0, 32'h0, 0);
        run_cmd(1'b0, 6'd5, 6'd40, 7'd5, 32'h0, 3);
        run_cmd(1'b1, 6'd0, 6'd20, 7'd4, 32'hA5A5A5A5, 5);

        poke(6'd0, 32'hA); poke(6'd1, 32'hB); poke(6'd2, 32'hC); poke(6'd3, 32'hD);
        run_cmd(1'b0, 6'd0, 6'd1, 7'd3, 32'h0, 0);
        for (int i = 0; i < 4; i++) check("overlap", ram[i], 32'hA);

        run_cmd(1'b1, 6'd0, 6'd17, 7'd64, 32'h5555AAAA, 0);
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        run_cmd(1'b0, 6'd50, 6'd50, 7'd64, 32'h0, 0);

        // Asynchronous reset during the third cycle of an 8-word FILL.
        f = 32'h0BADF00D;
        bus.start     = 1'b1;
        bus.mode      = 1'b1;
        bus.dst_addr  = 6'd0;
        bus.len       = 7'd8;
        bus.fill_data = f;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("ab_we", 32'(bus.mem_write_en), 32'd1);
            check("ab_addr", 32'(bus.mem_addr), 32'(c - 1));
        end
        ref_mem[0] = f;
        ref_mem[1] = f;
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_async_we", 32'(bus.mem_write_en), 32'd0);
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_addr0", 32'(bus.mem_addr), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("ab_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("ab_post_done", 32'(bus.done), 32'd0);
            check("ab_post_busy", 32'(bus.busy), 32'd0);
        end
        compare_mem("ab_mem");
        run_cmd(1'b0, 6'd0, 6'd30, 7'd6, 32'h0, 0);

        // Random commands, some with an ignored start during execution.
        for (int t = 0; t < 25; t++) begin
            logic       m;
            logic [6:0] n;
            int         inj;
            m   = 1'($urandom);
            n   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 64)) : 7'($urandom_range(0, 12));
            inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            run_cmd(m, 6'($urandom), 6'($urandom), n, $urandom, inj);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
